// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch-side PC generator.
// Holds the redirect FSM encoding and architectural widths.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator: sequential fetch, EX-stage redirects with same-cycle
// flushes, misaligned-target trap, and bring-up statistics counters.
module pc_redirect_unit
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_branch,
    input  logic [XLEN-1:0]  ex_target,
    output logic [XLEN-1:0]  pc_f,
    output logic [XLEN-1:0]  pc_plus4_f,
    output logic             fetch_valid,
    output logic             flush_d,
    output logic             flush_e,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    state_t state;
    logic   take;
    logic   bad;
    logic   running;

    // A jump wins when both type flags are set, so it is OR'd in unconditionally.
    // NOTE: every signal driven here is fully assigned on each evaluation, so no latch.
    always_comb begin
        take    = ex_valid & (ex_is_jump | (ex_is_branch & ex_branch));
        bad     = take & (ex_target[1:0] != 2'b00);
        running = (state == RUN);
    end

    assign flush_d    = running & take;
    assign flush_e    = running & take;
    assign pc_plus4_f = pc_f + XLEN'(INST_BYTES);

    // NOTE: state lives behind non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc_f         <= RESET_PC;
            fetch_valid  <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    // The EX instruction is older than the stalled fetch, so it redirects first.
                    if (bad) begin
                        state        <= TRAP;
                        pc_f         <= TRAP_VEC;
                        fetch_valid  <= 1'b0;
                        misalign_exc <= 1'b1;
                    end else if (take) begin
                        pc_f <= ex_target;
                    end else if (!stall_f) begin
                        pc_f <= pc_plus4_f;
                    end
                end
                TRAP: begin
                    state        <= RUN;
                    fetch_valid  <= 1'b1;
                    misalign_exc <= 1'b0;
                end
                default: begin
                    state        <= BOOT;
                    pc_f         <= RESET_PC;
                    fetch_valid  <= 1'b0;
                    misalign_exc <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (running & ex_valid & ex_is_branch),
        .cnt (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (running & take),
        .cnt (taken_cnt)
    );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_pc_redirect_unit;

    localparam int          TB_CNT_W = 6;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall_f;
    logic                ex_valid;
    logic                ex_is_branch;
    logic                ex_is_jump;
    logic                ex_branch;
    logic [31:0]         ex_target;
    logic [31:0]         pc_f;
    logic [31:0]         pc_plus4_f;
    logic                fetch_valid;
    logic                flush_d;
    logic                flush_e;
    logic                misalign_exc;
    logic [TB_CNT_W-1:0] branch_cnt;
    logic [TB_CNT_W-1:0] taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pc_redirect_unit #(
        .RESET_PC (RST_PC),
        .TRAP_VEC (TRAP_PC),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_f      (stall_f),
        .ex_valid     (ex_valid),
        .ex_is_branch (ex_is_branch),
        .ex_is_jump   (ex_is_jump),
        .ex_branch    (ex_branch),
        .ex_target    (ex_target),
        .pc_f         (pc_f),
        .pc_plus4_f   (pc_plus4_f),
        .fetch_valid  (fetch_valid),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .misalign_exc (misalign_exc),
        .branch_cnt   (branch_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs change mid-low-phase; outputs are sampled 1 ns later, far from the rising edge.
    task automatic apply(input logic r, input logic v, input logic br, input logic jp,
                         input logic res, input logic st, input logic [31:0] tgt);
        rst = r; ex_valid = v; ex_is_branch = br; ex_is_jump = jp;
        ex_branch = res; stall_f = st; ex_target = tgt;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the DUT in RUN with pc_f = RESET_PC.
    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        tick();
        idle();
        n_cmp++; if (pc_f !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_f, RST_PC); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (misalign_exc !== 1'b0) begin n_err++; $display("FAIL reset_exc: got %b want 0", misalign_exc); end
        n_cmp++; if ((branch_cnt !== '0) || (taken_cnt !== '0)) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt, taken_cnt); end
        tick();
        for (int i = 0; i < 4; i++) begin
            idle();
            n_cmp++; if (pc_f !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_f, 32'(4 * i)); end
            n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq_fetch_valid[%0d]: got %b want 1", i, fetch_valid); end
            n_cmp++; if ((flush_d | flush_e) !== 1'b0) begin n_err++; $display("FAIL seq_flush[%0d]: got %b%b want 00", i, flush_d, flush_e); end
            tick();
        end
    endtask

    task automatic test_taken_branch();
        do_reset();
        repeat (4) begin idle(); tick(); end
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        n_cmp++; if (pc_f !== 32'h10) begin n_err++; $display("FAIL br_start_pc: got %h want 00000010", pc_f); end
        n_cmp++; if ({flush_d, flush_e} !== 2'b11) begin n_err++; $display("FAIL br_flush: got %b%b want 11", flush_d, flush_e); end
        tick();
        idle();
        n_cmp++; if (pc_f !== 32'h40) begin n_err++; $display("FAIL br_target_pc: got %h want 00000040", pc_f); end
        n_cmp++; if ((branch_cnt !== 6'd1) || (taken_cnt !== 6'd1)) begin n_err++; $display("FAIL br_cnt: got %0d/%0d want 1/1", branch_cnt, taken_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            n_cmp++; if (pc_f !== 32'h20) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 00000020", i, pc_f); end
            tick();
        end
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080);
        n_cmp++; if ({flush_d, flush_e} !== 2'b11) begin n_err++; $display("FAIL stall_jump_flush: got %b%b want 11", flush_d, flush_e); end
        tick();
        idle();
        n_cmp++; if (pc_f !== 32'h80) begin n_err++; $display("FAIL stall_jump_pc: got %h want 00000080", pc_f); end
    endtask

    task automatic test_misalign();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0042);
        n_cmp++; if ({flush_d, flush_e} !== 2'b11) begin n_err++; $display("FAIL mis_flush: got %b%b want 11", flush_d, flush_e); end
        tick();
        // Inputs in TRAP must be ignored: a take here neither flushes nor redirects.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        n_cmp++; if (pc_f !== TRAP_PC) begin n_err++; $display("FAIL mis_trap_pc: got %h want %h", pc_f, TRAP_PC); end
        n_cmp++; if (misalign_exc !== 1'b1) begin n_err++; $display("FAIL mis_exc: got %b want 1", misalign_exc); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL mis_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if ((flush_d | flush_e) !== 1'b0) begin n_err++; $display("FAIL mis_trap_flush: got %b%b want 00", flush_d, flush_e); end
        n_cmp++; if (taken_cnt !== 6'd1) begin n_err++; $display("FAIL mis_taken_cnt: got %0d want 1", taken_cnt); end
        tick();
        idle();
        n_cmp++; if ((pc_f !== TRAP_PC) || (misalign_exc !== 1'b0) || (fetch_valid !== 1'b1)) begin
            n_err++; $display("FAIL mis_after_trap: got pc=%h exc=%b fv=%b want pc=%h exc=0 fv=1", pc_f, misalign_exc, fetch_valid, TRAP_PC);
        end
        tick();
        idle();
        n_cmp++; if (pc_f !== 32'h104) begin n_err++; $display("FAIL mis_resume_pc: got %h want 00000104", pc_f); end
    endtask

    task automatic test_not_taken();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
        n_cmp++; if ((flush_d | flush_e) !== 1'b0) begin n_err++; $display("FAIL nt_flush: got %b%b want 00", flush_d, flush_e); end
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        n_cmp++; if ((flush_d | flush_e) !== 1'b0) begin n_err++; $display("FAIL inv_flush: got %b%b want 00", flush_d, flush_e); end
        n_cmp++; if (pc_f !== 32'h4) begin n_err++; $display("FAIL nt_pc: got %h want 00000004", pc_f); end
        tick();
        idle();
        n_cmp++; if (pc_f !== 32'h8) begin n_err++; $display("FAIL inv_pc: got %h want 00000008", pc_f); end
        n_cmp++; if ((branch_cnt !== 6'd1) || (taken_cnt !== 6'd0)) begin n_err++; $display("FAIL nt_cnt: got %0d/%0d want 1/0", branch_cnt, taken_cnt); end
    endtask

    task automatic test_boundaries();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        tick();
        idle();
        n_cmp++; if ((pc_f !== 32'hFFFF_FFFC) || (pc_plus4_f !== 32'h0)) begin
            n_err++; $display("FAIL wrap_pre: got pc=%h p4=%h want fffffffc/00000000", pc_f, pc_plus4_f);
        end
        tick();
        // rst together with a take: the reset must win.
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300);
        n_cmp++; if (pc_f !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 00000000", pc_f); end
        tick();
        idle();
        n_cmp++; if ((pc_f !== RST_PC) || (fetch_valid !== 1'b0) || (taken_cnt !== '0)) begin
            n_err++; $display("FAIL rst_vs_take: got pc=%h fv=%b tc=%0d want %h/0/0", pc_f, fetch_valid, taken_cnt, RST_PC);
        end
        tick();
        for (int i = 0; i < CNT_MAX + 8; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
            tick();
        end
        idle();
        n_cmp++; if ((branch_cnt !== '1) || (taken_cnt !== '1)) begin
            n_err++; $display("FAIL sat_cnt: got %0d/%0d want %0d/%0d", branch_cnt, taken_cnt, CNT_MAX, CNT_MAX);
        end
    endtask

    // Reference model: pc, a boot/trap bubble flag each, and integer counters clipped at CNT_MAX.
    task automatic test_random();
        logic [31:0] m_pc;
        bit          m_boot;
        bit          m_trap;
        int          m_bc;
        int          m_tc;
        logic [31:0] tgt;
        logic        r, v, br, jp, res, st;
        bit          take, bad, live;
        int          errs_before;
        do_reset();
        m_pc = RST_PC; m_boot = 0; m_trap = 0; m_bc = 0; m_tc = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r   = ($urandom_range(0, 79) == 0);
            v   = ($urandom_range(0, 3) != 0);
            br  = $urandom_range(0, 1);
            jp  = ($urandom_range(0, 3) == 0);
            res = $urandom_range(0, 1);
            st  = ($urandom_range(0, 3) == 0);
            tgt = $urandom();
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            apply(r, v, br, jp, res, st, tgt);

            take = v && ((br && res) || jp);
            bad  = take && (tgt[1:0] != 2'b00);
            live = !m_boot && !m_trap;
            errs_before = n_err;
            n_cmp++; if (pc_f !== m_pc) begin n_err++; $display("FAIL rnd_pc @%0d: got %h want %h", cyc, pc_f, m_pc); end
            n_cmp++; if (pc_plus4_f !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4 @%0d: got %h want %h", cyc, pc_plus4_f, m_pc + 32'd4); end
            n_cmp++; if (fetch_valid !== live) begin n_err++; $display("FAIL rnd_fv @%0d: got %b want %b", cyc, fetch_valid, live); end
            n_cmp++; if (misalign_exc !== m_trap) begin n_err++; $display("FAIL rnd_exc @%0d: got %b want %b", cyc, misalign_exc, m_trap); end
            n_cmp++; if ({flush_d, flush_e} !== {2{live && take}}) begin n_err++; $display("FAIL rnd_flush @%0d: got %b%b want %b", cyc, flush_d, flush_e, live && take); end
            n_cmp++; if (branch_cnt !== TB_CNT_W'(m_bc)) begin n_err++; $display("FAIL rnd_bc @%0d: got %0d want %0d", cyc, branch_cnt, m_bc); end
            n_cmp++; if (taken_cnt !== TB_CNT_W'(m_tc)) begin n_err++; $display("FAIL rnd_tc @%0d: got %0d want %0d", cyc, taken_cnt, m_tc); end
            if (n_err - errs_before > 0 && n_err > 40) begin
                $display("FAIL rnd_abort: too many mismatches");
                break;
            end

            if (r) begin
                m_pc = RST_PC; m_boot = 1; m_trap = 0; m_bc = 0; m_tc = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (m_trap) begin
                m_trap = 0;
            end else begin
                if (v && br) m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
                if (take)    m_tc = (m_tc < CNT_MAX) ? m_tc + 1 : CNT_MAX;
                if (bad) begin
                    m_pc = TRAP_PC; m_trap = 1;
                end else if (take) begin
                    m_pc = tgt;
                end else if (!st) begin
                    m_pc = m_pc + 32'd4;
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
        ex_is_jump = 1'b0; ex_branch = 1'b0; ex_target = 32'h0;
        @(negedge clk);
        test_reset();
        test_taken_branch();
        test_stall();
        test_misalign();
        test_not_taken();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side PC generator, directly downstream of the EX-stage branch comparator.
- Each cycle it holds the fetch PC and consumes the comparator's 1-bit branch result plus the EX target address.
- It redirects the PC, flushes the IF/ID and ID/EX pipeline registers, and traps misaligned targets.
- It also keeps branch and taken statistics counters for bring-up.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a redirect target is misaligned.
- CNT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_f  in  1  hazard-unit stall; hold the PC when asserted.
- ex_valid  in  1  EX stage holds a real, unflushed instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jump  in  1  EX instruction is jal/jalr (unconditional).
- ex_branch  in  1  comparator result; meaningful only when ex_is_branch=1.
- ex_target  in  32  branch/jump target computed in EX.
- pc_f  out  32  current fetch PC (registered).
- pc_plus4_f  out  32  pc_f + 4, combinational.
- fetch_valid  out  1  pc_f is a fetchable address this cycle.
- flush_d  out  1  clear IF/ID register (combinational).
- flush_e  out  1  clear ID/EX register (combinational).
- misalign_exc  out  1  one-cycle pulse: a redirect target was misaligned.
- branch_cnt  out  CNT_W  count of conditional branches retired in EX.
- taken_cnt  out  CNT_W  count of taken redirects (branches and jumps).

Behaviour:
- Definitions:
  - take = ex_valid & ((ex_is_branch & ex_branch) | ex_is_jump).
  - If ex_is_branch and ex_is_jump are both 1, it is treated as a jump.
  - bad = take & (ex_target[1:0] != 2'b00).
- Reset (sync, rst=1 at a rising edge):
  - pc_f = RESET_PC, state = BOOT.
  - fetch_valid = 0, misalign_exc = 0, both counters = 0.
  - rst dominates all other inputs, including in-flight redirects.
- FSM states:
  - BOOT: one cycle after reset. fetch_valid = 0, pc_f holds RESET_PC. Next state is RUN unconditionally; redirect and stall inputs are ignored.
  - RUN: fetch_valid = 1.
    - If take & !bad: pc_f <= ex_target, and flush_d = flush_e = 1 in the same cycle take is high.
    - If bad: pc_f <= TRAP_VEC, flushes asserted, misalign_exc <= 1 next cycle, state <= TRAP.
    - Otherwise, if stall_f: pc_f holds.
    - Otherwise: pc_f <= pc_f + 4, with mod-2^32 wrap (32'hFFFF_FFFC -> 0).
  - TRAP: one cycle. misalign_exc = 1, fetch_valid = 0. State <= RUN; pc_f holds TRAP_VEC. take/stall_f inputs are ignored in this cycle.
- Priority in RUN: rst > redirect (bad or take) > stall_f > sequential increment.
  - A redirect overrides stall_f, because the EX instruction is older than the stalled fetch.
- Flush signals are purely combinational from take, and only in RUN. Zero latency: the comparator result and the flush land in the same cycle.
- Redirect latency: pc_f shows the new target one clock after take.
- Back-to-back takes on consecutive cycles are legal; each one redirects. In practice the flush makes the second ex_valid=0.
- Counters:
  - Updated at the clock edge, in RUN only.
  - branch_cnt increments on ex_valid & ex_is_branch.
  - taken_cnt increments on take, including bad.
  - Both saturate at all-ones; no wrap.
- pc_f[1:0] is always 2'b00.

Decomposition:
- Shared package `pipe_pkg`:
  - FSM enum (BOOT, RUN, TRAP), 2 bits.
  - Localparams: XLEN=32, INST_BYTES=4.
- Sub-module `sat_counter` (parameter W; inputs clk, rst, inc; output cnt), instantiated twice.
- The PC/FSM logic stays in this module.

Test Plan:
1. Reset release -> pc_f=0, fetch_valid=0 for 1 cycle. Then pc_f = 0, 4, 8, 12 on successive cycles; flushes stay 0.
2. At pc_f=0x10, ex_valid=1, ex_is_branch=1, ex_branch=1, ex_target=0x40 -> flush_d = flush_e = 1 that cycle; next cycle pc_f=0x40; branch_cnt=1, taken_cnt=1.
3. stall_f=1 for 3 cycles at pc_f=0x20 -> pc_f stays 0x20. Then the same stall plus a jump to 0x80 -> the redirect wins; pc_f=0x80 next cycle.
4. Taken branch to 0x42 -> pc_f=0x100 and misalign_exc=1 for exactly one cycle, fetch_valid=0 during TRAP. Then pc_f=0x104; taken_cnt increments.
5. Not-taken branch (ex_branch=0), and ex_branch=1 with ex_valid=0 -> no flush, sequential PC; branch_cnt counts only the valid case.
6. Preload pc_f=0xFFFF_FFFC -> next pc_f=0. rst asserted in the same cycle as take -> pc_f=RESET_PC, no redirect. Counters forced to all-ones saturate on the next increment.
